bcd_inc_scheduler: RTL and testbench

BCD_INC_SCHEDULER -- requirements
Module: bcd_inc_scheduler

---
 rtl/bcd_inc_scheduler.sv | 137 +++++++++++++
 tb/tb_bcd_inc_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_inc_scheduler.sv
// bcd_inc_scheduler: time-shares one external registered BCD incrementor
// among NCH three-digit BCD counters, granting requests round-robin.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - per-channel increment request (level, held until ack)
//   clr      - per-channel synchronous clear of count and wrap flag
//   ack      - per-channel completion strobe, high during CAPTURE only
//   busy     - high whenever the FSM is not idle
//   inc_bcd  - operand to the external incrementor (000 when idle)
//   inc_y    - incrementor result, valid one edge after inc_bcd
//   cnt_sel  - read-port channel select
//   cnt_rd   - combinational read of the selected count (000 if out of range)
//   wrap     - sticky per-channel 999->000 rollover flag
module bcd_inc_scheduler #(
    parameter int unsigned NCH = 4,
    localparam int unsigned SW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  clr,
    output logic [NCH-1:0]  ack,
    output logic            busy,
    output logic [11:0]     inc_bcd,
    input  logic [11:0]     inc_y,
    input  logic [SW-1:0]   cnt_sel,
    output logic [11:0]     cnt_rd,
    output logic [NCH-1:0]  wrap
);

    localparam int unsigned DW = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    count [NCH];
    logic [SW-1:0]    grant;      // doubles as last_grant between operations
    logic [SW-1:0]    pick;
    logic [SW-1:0]    idx;
    logic             pick_vld;
    logic [NCH-1:0]   elig;
    logic             abort;

    // Round-robin pick: scan from grant+1, channels being cleared are ineligible.
    always_comb begin
        elig     = req & ~clr;
        pick     = grant;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= int'(NCH); k++) begin
            idx = SW'((32'(grant) + 32'(k)) % NCH);
            if (!pick_vld && elig[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and incrementor-side outputs.
    always_comb begin
        state_n = state;
        ack     = '0;
        busy    = (state != IDLE);
        inc_bcd = '0;
        case (state)
            IDLE: begin
                if (pick_vld) state_n = ISSUE;
            end
            ISSUE: begin
                state_n = CAPTURE;
                inc_bcd = count[grant];
            end
            CAPTURE: begin
                state_n    = IDLE;
                inc_bcd    = count[grant];
                ack[grant] = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant capture and abort tracking for a clear of the in-flight channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= SW'(NCH - 1);
            abort <= 1'b0;
        end else begin
            if (state == IDLE) begin
                abort <= 1'b0;
                if (pick_vld) grant <= pick;
            end else if (clr[grant]) begin
                abort <= 1'b1;
            end
        end
    end

    // Count and wrap storage: clears first, then writeback unless aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) count[i] <= '0;
            wrap <= '0;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (clr[i]) begin
                    count[i] <= '0;
                    wrap[i]  <= 1'b0;
                end
            end
            if (state == CAPTURE && !abort && !clr[grant]) begin
                count[grant] <= inc_y;
                if (count[grant] == 12'h999) wrap[grant] <= 1'b1;
            end
        end
    end

    // Read port.
    always_comb begin
        cnt_rd = '0;
        if (32'(cnt_sel) < NCH) cnt_rd = count[cnt_sel];
    end

endmodule

// File: tb/tb_bcd_inc_scheduler.sv
// Directed testbench for bcd_inc_scheduler (NCH=4) with a registered
// BCD +1 model standing in for the external incrementor.
module tb_bcd_inc_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic        busy;
    logic [11:0] inc_bcd;
    logic [11:0] inc_y;
    logic [1:0]  cnt_sel;
    logic [11:0] cnt_rd;
    logic [3:0]  wrap;

    int passed = 0;
    int total  = 0;

    bcd_inc_scheduler #(.NCH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .clr     (clr),
        .ack     (ack),
        .busy    (busy),
        .inc_bcd (inc_bcd),
        .inc_y   (inc_y),
        .cnt_sel (cnt_sel),
        .cnt_rd  (cnt_rd),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_plus1(input logic [11:0] x);
        logic [3:0] d0, d1, d2;
        d0 = x[3:0];
        d1 = x[7:4];
        d2 = x[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // External incrementor: one-edge latency.
    always_ff @(posedge clk) inc_y <= bcd_plus1(inc_bcd);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_cnt(input int sel, output logic [11:0] v);
        cnt_sel = 2'(sel);
        #1;
        v = cnt_rd;
    endtask

    // One full increment on a channel; starts and ends in IDLE.
    task automatic do_inc(input int ch);
        bit got;
        got = 1'b0;
        req[ch] = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (ack[ch]) got = 1'b1;
        end
        req[ch] = 1'b0;
        if (!got) begin
            total++;
            $error("FAIL inc_timeout ch%0d: observed no ack, expected ack", ch);
        end
        step();
    endtask

    logic [11:0] v;
    logic [3:0]  order [4];
    int          n_ack;
    logic        busy_at11;
    logic        saw_ack;

    initial begin
        rst = 1'b1; req = '0; clr = '0; cnt_sel = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_inc_bcd", 32'(inc_bcd), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0;
        step();

        // Single request on channel 0.
        req = 4'b0001;
        step();
        chk("t1_issue_busy", 32'(busy), 32'h1);
        chk("t1_issue_ack", 32'(ack), 32'h0);
        chk("t1_issue_inc_bcd", 32'(inc_bcd), 32'h000);
        step();
        chk("t1_capture_ack", 32'(ack), 32'h1);
        req = '0;
        step();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            read_cnt(i, v);
            chk($sformatf("t1_cnt%0d", i), 32'(v), (i == 0) ? 32'h001 : 32'h000);
        end

        // Request masked by a same-cycle clear in IDLE.
        req = 4'b0010; clr = 4'b0010;
        step();
        chk("clr_mask_busy", 32'(busy), 32'h0);
        req = '0; clr = '0;

        // Channel 1 up to 999 then rollover.
        repeat (999) do_inc(1);
        read_cnt(1, v);
        chk("t2_cnt999", 32'(v), 32'h999);
        chk("t2_wrap_pre", 32'(wrap), 32'h0);
        do_inc(1);
        read_cnt(1, v);
        chk("t2_cnt_roll", 32'(v), 32'h000);
        chk("t2_wrap_set", 32'(wrap), 32'h2);
        clr = 4'b0010;
        step();
        clr = '0;
        chk("t2_wrap_clr", 32'(wrap), 32'h0);

        // Fresh reset before the all-channel round robin.
        rst = 1'b1;
        #1;
        read_cnt(0, v);
        chk("rst2_cnt0", 32'(v), 32'h000);
        step();
        rst = 1'b0;

        // All four channels requesting; each drops on its ack.
        for (int i = 0; i < 4; i++) order[i] = '0;
        n_ack = 0;
        busy_at11 = 1'b0;
        req = 4'b1111;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            if (cyc == 11) busy_at11 = busy;
            if (ack != 4'b0000) begin
                if (n_ack < 4) order[n_ack] = ack;
                n_ack++;
                req = req & ~ack;
            end
        end
        chk("t3_n_ack", 32'(n_ack), 32'd4);
        chk("t3_order0", 32'(order[0]), 32'h1);
        chk("t3_order1", 32'(order[1]), 32'h2);
        chk("t3_order2", 32'(order[2]), 32'h4);
        chk("t3_order3", 32'(order[3]), 32'h8);
        chk("t3_busy_c11", 32'(busy_at11), 32'h1);
        chk("t3_idle_c12", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            read_cnt(i, v);
            chk($sformatf("t3_cnt%0d", i), 32'(v), 32'h001);
        end

        // Clear of the in-flight channel during CAPTURE aborts writeback.
        req = 4'b0100;
        step();
        chk("t4_issue_busy", 32'(busy), 32'h1);
        step();
        chk("t4_ack", 32'(ack), 32'h4);
        clr = 4'b0100; req = '0;
        step();
        clr = '0;
        chk("t4_idle", 32'(busy), 32'h0);
        read_cnt(2, v);
        chk("t4_cnt2", 32'(v), 32'h000);
        read_cnt(3, v);
        chk("t4_cnt3_untouched", 32'(v), 32'h001);

        // Digit carry 099 -> 100.
        repeat (98) do_inc(0);
        read_cnt(0, v);
        chk("t5_cnt099", 32'(v), 32'h099);
        chk("t5_idle_inc_bcd", 32'(inc_bcd), 32'h000);
        req = 4'b0001;
        step();
        chk("t5_issue_inc_bcd", 32'(inc_bcd), 32'h099);
        step();
        chk("t5_capture_inc_bcd", 32'(inc_bcd), 32'h099);
        chk("t5_ack", 32'(ack), 32'h1);
        req = '0;
        step();
        read_cnt(0, v);
        chk("t5_cnt100", 32'(v), 32'h100);
        chk("t5_wrap", 32'(wrap), 32'h0);

        // Reset during ISSUE for channel 3 at 019.
        repeat (18) do_inc(3);
        read_cnt(3, v);
        chk("t6_cnt019", 32'(v), 32'h019);
        req = 4'b1000;
        step();
        chk("t6_issue_busy", 32'(busy), 32'h1);
        chk("t6_issue_inc_bcd", 32'(inc_bcd), 32'h019);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        chk("t6_rst_inc_bcd", 32'(inc_bcd), 32'h000);
        read_cnt(3, v);
        chk("t6_rst_cnt3", 32'(v), 32'h000);
        req = '0;
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (5) begin
            step();
            if (ack != 4'b0000) saw_ack = 1'b1;
        end
        chk("t6_no_ack", 32'(saw_ack), 32'h0);
        read_cnt(3, v);
        chk("t6_cnt3_after", 32'(v), 32'h000);
        chk("t6_wrap", 32'(wrap), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
